// File: rtl/beep_pkg.sv
// Shared constants for the beep tone path: note one-hots, alarm melody, FSM states.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package beep_pkg;

    localparam logic [7:0] NOTE_DO_M = 8'h01;
    localparam logic [7:0] NOTE_RE   = 8'h02;
    localparam logic [7:0] NOTE_MI   = 8'h04;
    localparam logic [7:0] NOTE_FA   = 8'h08;
    localparam logic [7:0] NOTE_SO   = 8'h10;
    localparam logic [7:0] NOTE_LA   = 8'h20;
    localparam logic [7:0] NOTE_SI   = 8'h40;
    localparam logic [7:0] NOTE_DO_H = 8'h80;

    // Alarm tune; the last step is a timed rest.
    localparam logic [7:0] MELODY [8] = '{
        NOTE_DO_M, NOTE_MI, NOTE_SO, NOTE_DO_H,
        NOTE_SO,   NOTE_MI, NOTE_DO_M, 8'h00
    };

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NOTE = 2'd1,
        GAP  = 2'd2
    } state_t;

    // Pass a key pattern only if exactly one key is down; chords and no-key are silence.
    function automatic logic [7:0] key_decode(input logic [7:0] keys);
        logic one_hot;
        one_hot = (keys != 8'h00) && ((keys & (keys - 8'h01)) == 8'h00);
        return one_hot ? keys : 8'h00;
    endfunction

endpackage

// File: rtl/beep_tick_gen.sv
// Prescaler producing a one-cycle tick strobe every TICK_DIV enabled cycles.
// Latency: first tick TICK_DIV cycles after clear is released with enable high.
// Backpressure: none; clear has priority over enable.
module beep_tick_gen #(
    parameter int TICK_DIV = 2_500_000
) (
    input  logic CLK_50M,
    input  logic RST_N,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = en && (cnt == LAST);

    // Count 0..TICK_DIV-1 while enabled, wrapping on the tick.
    always_ff @(posedge CLK_50M or negedge RST_N) begin
        if (!RST_N) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/beep_melody_ctrl.sv
// Arbitrates the tone generator between manual keys and an alarm melody sequencer.
// Latency: 1 cycle key-to-note; alarm start shows its first note at the sampling edge.
// Backpressure: none; requests while busy are dropped, stop beats request.
module beep_melody_ctrl
    import beep_pkg::*;
#(
    parameter int TICK_DIV   = 2_500_000,
    parameter int NOTE_TICKS = 6,
    parameter int GAP_TICKS  = 2,
    parameter int REPEAT     = 2
) (
    input  logic       CLK_50M,
    input  logic       RST_N,
    input  logic [7:0] KEY_IN,
    input  logic       ALARM_REQ,
    input  logic       ALARM_STOP,
    output logic [7:0] NOTE_OUT,
    output logic       ALARM_BUSY,
    output logic       ALARM_DONE
);

    localparam logic [7:0] NOTE_LAST = 8'(NOTE_TICKS - 1);
    localparam logic [7:0] GAP_LAST  = 8'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);
    localparam logic [3:0] PASS_LAST = (REPEAT < 1) ? 4'd1 : 4'(REPEAT);

    state_t     state, state_n;
    logic [2:0] step, step_n;
    logic [3:0] pass, pass_n;
    logic [7:0] tick_cnt, tick_cnt_n;
    logic [7:0] note_n;
    logic       done_n;
    logic       busy;
    logic       tick;

    assign busy       = (state != IDLE);
    assign ALARM_BUSY = busy;

    beep_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .CLK_50M (CLK_50M),
        .RST_N   (RST_N),
        .en      (busy),
        .clr     (!busy),
        .tick    (tick)
    );

    // Next state, counters and the note to register; note follows the next state so
    // step changes land on the same edge as the new note with no silent cycle.
    always_comb begin
        state_n    = state;
        step_n     = step;
        pass_n     = pass;
        tick_cnt_n = tick_cnt;
        note_n     = 8'h00;
        done_n     = 1'b0;
        case (state)
            IDLE: begin
                note_n = key_decode(KEY_IN);
                if (ALARM_REQ && !ALARM_STOP) begin
                    state_n    = NOTE;
                    step_n     = 3'd0;
                    pass_n     = 4'd1;
                    tick_cnt_n = 8'd0;
                    note_n     = MELODY[0];
                end
            end
            NOTE, GAP: begin
                note_n = (state == NOTE) ? MELODY[step] : 8'h00;
                if (ALARM_STOP) begin
                    state_n    = IDLE;
                    step_n     = 3'd0;
                    pass_n     = 4'd0;
                    tick_cnt_n = 8'd0;
                    note_n     = 8'h00;
                end else if (tick) begin
                    if (tick_cnt != ((state == NOTE) ? NOTE_LAST : GAP_LAST)) begin
                        tick_cnt_n = tick_cnt + 8'd1;
                    end else begin
                        tick_cnt_n = 8'd0;
                        if (state == NOTE && GAP_TICKS != 0) begin
                            state_n = GAP;
                            note_n  = 8'h00;
                        end else if (step != 3'd7) begin
                            state_n = NOTE;
                            step_n  = step + 3'd1;
                            note_n  = MELODY[step + 3'd1];
                        end else if (pass < PASS_LAST) begin
                            state_n = NOTE;
                            step_n  = 3'd0;
                            pass_n  = pass + 4'd1;
                            note_n  = MELODY[0];
                        end else begin
                            state_n = IDLE;
                            step_n  = 3'd0;
                            pass_n  = 4'd0;
                            note_n  = 8'h00;
                            done_n  = 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge CLK_50M or negedge RST_N) begin
        if (!RST_N) begin
            state      <= IDLE;
            step       <= 3'd0;
            pass       <= 4'd0;
            tick_cnt   <= 8'd0;
            NOTE_OUT   <= 8'h00;
            ALARM_DONE <= 1'b0;
        end else begin
            state      <= state_n;
            step       <= step_n;
            pass       <= pass_n;
            tick_cnt   <= tick_cnt_n;
            NOTE_OUT   <= note_n;
            ALARM_DONE <= done_n;
        end
    end

endmodule

// File: doc/beep_melody_ctrl.md
# beep_melody_ctrl

Sequencer and arbiter in front of the one-hot-note beep tone generator in the clock top level. It shares the tone generator between two requesters: manual keys, which sound a note while held, and the alarm, which plays a fixed 8-step melody with timed notes and rests. The alarm has priority over the keys. The block drives the tone generator's 8-bit one-hot note select. Zero means silence.

## Interface
Parameters:
- TICK_DIV, 2_500_000 — CLK_50M cycles per timing tick (50 ms).
- NOTE_TICKS, 6 — ticks each melody note sounds; legal range 1..255.
- GAP_TICKS, 2 — silent ticks after each note; 0 means no gap.
- REPEAT, 2 — melody passes per alarm; legal range 1..15, 0 treated as 1.

Ports:
- CLK_50M  in  1  system clock, 50 MHz.
- RST_N  in  1  reset, asynchronous, active-low.
- KEY_IN  in  8  debounced key levels; one-hot selects a note.
- ALARM_REQ  in  1  single-cycle pulse; starts the melody.
- ALARM_STOP  in  1  single-cycle pulse; aborts the melody.
- NOTE_OUT  out  8  registered one-hot note select to the tone generator; 0 = silent.
- ALARM_BUSY  out  1  high while the melody is active.
- ALARM_DONE  out  1  one-cycle pulse on natural completion only.

## Operation
- States:
  - IDLE: NOTE_OUT follows KEY_IN.
  - NOTE: NOTE_OUT = MELODY[step].
  - GAP: NOTE_OUT = 0.
- Manual path (IDLE only):
  - NOTE_OUT <= KEY_IN when KEY_IN has exactly one bit set; otherwise 0.
  - A multi-key press or no key gives silence.
- Melody ROM, steps 0..7: 01, 04, 10, 80, 10, 04, 01, 00 (hex). Step 7 is a timed rest.
- IDLE -> NOTE on ALARM_REQ:
  - step = 0, pass = 1.
  - Tick prescaler and tick counter cleared.
  - ALARM_BUSY = 1.
- NOTE -> GAP after NOTE_TICKS ticks. If GAP_TICKS = 0, go directly to next-step handling.
- GAP -> next-step handling after GAP_TICKS ticks.
- Next-step handling:
  - step < 7: step++, go to NOTE.
  - step = 7 and pass < REPEAT: step = 0, pass++, go to NOTE.
  - Otherwise: go to IDLE and pulse ALARM_DONE.
- ALARM_STOP in NOTE or GAP:
  - Go to IDLE on the next edge. NOTE_OUT = 0 that cycle, then the manual path resumes.
  - ALARM_DONE is not pulsed.
- While busy, KEY_IN is ignored and ALARM_REQ is ignored (no restart).
- ALARM_REQ and ALARM_STOP in the same cycle: STOP wins, whether in IDLE or busy.
- Prescaler:
  - Counter 0..TICK_DIV-1, width $clog2(TICK_DIV).
  - Runs only while busy; the tick strobe fires on the wrap.
- Tick counter: 8 bits, compared against NOTE_TICKS-1 or GAP_TICKS-1 on each tick strobe, cleared on every state change.
- Pass counter: 4 bits.

## Timing
- Reset values: NOTE_OUT = 0, ALARM_BUSY = 0, ALARM_DONE = 0, state IDLE, all counters 0.
- Reset asserted mid-melody: all outputs return to 0 immediately (asynchronous reset).
- Manual latency: 1 cycle from KEY_IN to NOTE_OUT.
- Alarm start: ALARM_REQ sampled at edge t. At edge t, NOTE_OUT = 01 and ALARM_BUSY = 1.
- Note length: each note holds for exactly NOTE_TICKS*TICK_DIV cycles.
- Gap length: each gap holds for exactly GAP_TICKS*TICK_DIV cycles.
- Total alarm length: REPEAT*8*(NOTE_TICKS+GAP_TICKS)*TICK_DIV cycles.
- Completion: ALARM_DONE is high in the first IDLE cycle, the same cycle ALARM_BUSY falls.
- Step boundaries produce no glitch or 0-cycle between two consecutive notes when GAP_TICKS = 0.

## Structure
- Shared package beep_pkg holds:
  - note one-hot constants NOTE_DO_M .. NOTE_DO_H;
  - the MELODY 8x8 constant;
  - the state encoding (IDLE, NOTE, GAP).
- Sub-module beep_tick_gen (prescaler with enable and synchronous clear, outputs a tick strobe).
- The FSM and counters stay in beep_melody_ctrl.

## Test plan
All scenarios use TICK_DIV=4, NOTE_TICKS=2, GAP_TICKS=1, REPEAT=1, so a note lasts 8 cycles and a gap 4 cycles.
- Manual keys:
  - KEY_IN=08 -> NOTE_OUT=08 one cycle later.
  - KEY_IN=09 -> NOTE_OUT=00.
  - KEY_IN=00 -> NOTE_OUT=00.
- Full alarm from ALARM_REQ:
  - NOTE_OUT sequence 01(8 cycles), 00(4), 04(8), 00(4), 10, 00, 80, 00, 10, 00, 04, 00, 01, 00, 00(8), 00(4).
  - ALARM_BUSY high for 96 cycles, then ALARM_DONE for one cycle.
- Priority: KEY_IN=80 held during the alarm -> ignored. After ALARM_DONE, NOTE_OUT=80 one cycle later.
- Abort: ALARM_STOP during step 3 -> NOTE_OUT=00 and ALARM_BUSY=0 next cycle, no ALARM_DONE.
- Request while busy: ALARM_REQ at cycle 20 -> ignored; total alarm length unchanged.
- Simultaneous pulses: ALARM_REQ and ALARM_STOP together in IDLE -> no start.
- REPEAT=2: 192 busy cycles, step wraps 7 -> 0 with no extra gap.
- RST_N low mid-note -> all outputs 0 immediately.
